// File: rtl/bp_pkg.sv
// Shared encodings and helpers for branch resolution and BTB direction counters.
// Entry flags only; tag/target widths depend on XLEN and live in the top's arrays.
package bp_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic       valid;
    logic       is_jump;
    logic [1:0] ctr;
  } btb_entry_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// RV32I conditional-branch comparator selected by funct3; purely combinational.
// Reserved codes 010/011 report not taken.
module branch_cond
  import bp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            cond
);

  always_comb begin
    cond = 1'b0;
    case (funct3)
      BEQ:     cond = (a == b);
      BNE:     cond = (a != b);
      BLT:     cond = ($signed(a) <  $signed(b));
      BGE:     cond = ($signed(a) >= $signed(b));
      BLTU:    cond = (a <  b);
      BGEU:    cond = (a >= b);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB lookup (comb, read-before-write) plus same-cycle branch resolve;
// tables and counters update on the edge after resolve. No backpressure.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_immext,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            take_branch,
  output logic [XLEN-1:0] pc_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  btb_entry_t            meta    [ENTRIES];
  logic [TAG_W-1:0]      tag_mem [ENTRIES];
  logic [XLEN-1:0]       tgt_mem [ENTRIES];

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit, cond, resolve;
  logic [XLEN-1:0]  jalr_sum;
  btb_entry_t       meta_nxt;
  logic             meta_we, tag_we, tgt_we;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[XLEN-1:IDX_W+2];
  assign e_idx = ex_pc[IDX_W+1:2];
  assign e_tag = ex_pc[XLEN-1:IDX_W+2];

  assign f_hit       = meta[f_idx].valid && (tag_mem[f_idx] == f_tag);
  assign pred_taken  = f_hit && (meta[f_idx].is_jump || meta[f_idx].ctr[1]);
  assign pred_target = pred_taken ? tgt_mem[f_idx] : fetch_pc + XLEN'(4);

  branch_cond #(.XLEN(XLEN)) u_cond (
    .funct3 (ex_funct3),
    .a      (ex_rs1),
    .b      (ex_rs2),
    .cond   (cond)
  );

  assign jalr_sum    = ex_rs1 + ex_immext;
  assign pc_target   = ex_jalr ? (jalr_sum & ~XLEN'(1)) : ex_pc + ex_immext;
  assign take_branch = ex_valid && (ex_jump || (ex_branch && cond));
  assign mispredict  = ex_valid && ((take_branch != ex_pred_taken) ||
                                    (take_branch && (pc_target != ex_pred_target)));
  assign redirect_pc = take_branch ? pc_target : ex_pc + XLEN'(4);
  assign resolve     = ex_valid && (ex_branch || ex_jump);

  assign e_hit = meta[e_idx].valid && (tag_mem[e_idx] == e_tag);

  always_comb begin
    meta_nxt = meta[e_idx];
    meta_we  = 1'b0;
    tag_we   = 1'b0;
    tgt_we   = 1'b0;
    if (resolve) begin
      if (ex_jump) begin
        meta_nxt = '{valid: 1'b1, is_jump: 1'b1, ctr: ST};
        meta_we  = 1'b1;
        tag_we   = 1'b1;
        tgt_we   = 1'b1;
      end else if (e_hit) begin
        meta_nxt.ctr = take_branch ? sat_inc(meta[e_idx].ctr) : sat_dec(meta[e_idx].ctr);
        meta_we      = 1'b1;
        tgt_we       = take_branch;
      end else if (take_branch) begin
        meta_nxt = '{valid: 1'b1, is_jump: 1'b0, ctr: WT};
        meta_we  = 1'b1;
        tag_we   = 1'b1;
        tgt_we   = 1'b1;
      end
    end else if (ex_valid && ex_pred_taken) begin
      // a non-control instruction was predicted taken through aliasing
      meta_nxt.valid = 1'b0;
      meta_we        = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        meta[i] <= '{valid: 1'b0, is_jump: 1'b0, ctr: WNT};
      end
    end else if (meta_we) begin
      meta[e_idx] <= meta_nxt;
    end
  end

  // tag/target need no reset: they are only observed through a set valid bit
  always_ff @(posedge clk) begin
    if (tag_we) tag_mem[e_idx] <= e_tag;
    if (tgt_we) tgt_mem[e_idx] <= pc_target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (resolve && (branch_count != '1))
        branch_count <= branch_count + CNT_W'(1);
      if (mispredict && (mispredict_count != '1))
        mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a negedge monitor compares.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        ex_valid, ex_branch, ex_jump, ex_jalr, ex_pred_taken;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_immext, ex_rs1, ex_rs2, ex_pred_target;

  logic        pred_taken, take_branch, mispredict;
  logic [31:0] pred_target, pc_target, redirect_pc, branch_count, mispredict_count;
  logic        pred_taken4, take_branch4, mispredict4;
  logic [31:0] pred_target4, pc_target4, redirect_pc4;
  logic [3:0]  branch_count4, mispredict_count4;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_immext(ex_immext),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .take_branch(take_branch), .pc_target(pc_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_predict_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken4), .pred_target(pred_target4),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_immext(ex_immext),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .take_branch(take_branch4), .pc_target(pc_target4),
    .mispredict(mispredict4), .redirect_pc(redirect_pc4),
    .branch_count(branch_count4), .mispredict_count(mispredict_count4)
  );

  typedef struct {
    string       nm;
    int          kind;
    logic [31:0] val;
  } chk_t;

  chk_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_bc = 0;
  int   exp_mc = 0;

  task automatic push(input string nm, input int kind, input logic [31:0] val);
    chk_t c;
    c.nm = nm; c.kind = kind; c.val = val;
    q.push_back(c);
  endtask

  task automatic push_counts(input string nm);
    push({nm, ".branch_count"}, 6, exp_bc);
    push({nm, ".mispredict_count"}, 7, exp_mc);
    push({nm, ".mispredict_count_w4"}, 8, (exp_mc > 15) ? 32'hF : exp_mc);
  endtask

  initial begin : monitor
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        c = q.pop_front();
        case (c.kind)
          0:       act = {31'b0, pred_taken};
          1:       act = pred_target;
          2:       act = {31'b0, take_branch};
          3:       act = pc_target;
          4:       act = {31'b0, mispredict};
          5:       act = redirect_pc;
          6:       act = branch_count;
          7:       act = mispredict_count;
          default: act = {28'b0, mispredict_count4};
        endcase
        checks++;
        if (act !== c.val) begin
          errors++;
          $display("FAIL %s: actual=%h expected=%h", c.nm, act, c.val);
        end
      end
    end
  end

  // idle execute slot: control bits set but ex_valid low must suppress everything
  task automatic look(input string nm, input logic [31:0] fpc,
                      input logic e_pt, input logic [31:0] e_ptg);
    @(posedge clk); #1;
    fetch_pc = fpc;
    ex_valid = 1'b0; ex_branch = 1'b1; ex_jump = 1'b1; ex_jalr = 1'b0;
    ex_pred_taken = 1'b1; ex_pred_target = 32'h0;
    push({nm, ".pred_taken"}, 0, {31'b0, e_pt});
    push({nm, ".pred_target"}, 1, e_ptg);
    push({nm, ".take_branch"}, 2, 32'h0);
    push({nm, ".mispredict"}, 4, 32'h0);
    push_counts(nm);
  endtask

  task automatic resolve(input string nm, input logic br, input logic jp, input logic jr,
                         input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic pt, input logic [31:0] ptg, input logic [31:0] fpc,
                         input logic e_take, input logic [31:0] e_tgt, input logic e_mis,
                         input logic [31:0] e_red, input logic e_pt, input logic [31:0] e_ptg);
    @(posedge clk); #1;
    fetch_pc = fpc;
    ex_valid = 1'b1; ex_branch = br; ex_jump = jp; ex_jalr = jr; ex_funct3 = f3;
    ex_pc = pc; ex_immext = imm; ex_rs1 = r1; ex_rs2 = r2;
    ex_pred_taken = pt; ex_pred_target = ptg;
    push({nm, ".pred_taken"}, 0, {31'b0, e_pt});
    push({nm, ".pred_target"}, 1, e_ptg);
    push({nm, ".take_branch"}, 2, {31'b0, e_take});
    push({nm, ".pc_target"}, 3, e_tgt);
    push({nm, ".mispredict"}, 4, {31'b0, e_mis});
    push({nm, ".redirect_pc"}, 5, e_red);
    push_counts(nm);
    if (br || jp) exp_bc++;
    if (e_mis) exp_mc++;
  endtask

  initial begin
    rst = 1'b1; fetch_pc = 32'h0;
    ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0; ex_jalr = 1'b0;
    ex_funct3 = 3'b0; ex_pc = 32'h0; ex_immext = 32'h0; ex_rs1 = 32'h0; ex_rs2 = 32'h0;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    look("reset", 32'h100, 1'b0, 32'h104);
    //       name      br jp jr f3      pc          imm          rs1          rs2      pt ptg          fpc          take tgt          mis red          pt ptg
    resolve("blt",     1, 0, 0, 3'b100, 32'h200,    32'h40,      32'hFFFFFFFF, 32'h1,  0, 32'h0,      32'h200,     1, 32'h240,      1, 32'h240,      0, 32'h204);
    resolve("bltu",    1, 0, 0, 3'b110, 32'h200,    32'h40,      32'hFFFFFFFF, 32'h1,  1, 32'h240,    32'h200,     0, 32'h240,      1, 32'h204,      1, 32'h240);
    resolve("jalr",    0, 1, 1, 3'b000, 32'h308,    32'h0,       32'h1003,     32'h0,  0, 32'h0,      32'h200,     1, 32'h1002,     1, 32'h1002,     0, 32'h204);
    resolve("jalr_rp", 0, 1, 1, 3'b000, 32'h308,    32'h0,       32'h1003,     32'h0,  1, 32'h1002,   32'h308,     1, 32'h1002,     0, 32'h1002,     1, 32'h1002);
    look("alias", 32'h1308, 1'b0, 32'h130C);
    resolve("nonbr",   0, 0, 0, 3'b000, 32'h308,    32'h0,       32'h0,        32'h0,  1, 32'h1002,   32'h308,     0, 32'h308,      1, 32'h30C,      1, 32'h1002);
    look("invalid", 32'h308, 1'b0, 32'h30C);
    resolve("beq_t1",  1, 0, 0, 3'b000, 32'h410,    32'h10,      32'h5,        32'h5,  0, 32'h0,      32'h410,     1, 32'h420,      1, 32'h420,      0, 32'h414);
    resolve("beq_t2",  1, 0, 0, 3'b000, 32'h410,    32'h10,      32'h5,        32'h5,  1, 32'h420,    32'h410,     1, 32'h420,      0, 32'h420,      1, 32'h420);
    resolve("beq_t3",  1, 0, 0, 3'b000, 32'h410,    32'h10,      32'h5,        32'h5,  1, 32'h999,    32'h410,     1, 32'h420,      1, 32'h420,      1, 32'h420);
    resolve("beq_t4",  1, 0, 0, 3'b000, 32'h410,    32'h10,      32'h5,        32'h5,  1, 32'h420,    32'h410,     1, 32'h420,      0, 32'h420,      1, 32'h420);
    resolve("beq_n1",  1, 0, 0, 3'b000, 32'h410,    32'h10,      32'h5,        32'h7,  1, 32'h420,    32'h410,     0, 32'h420,      1, 32'h414,      1, 32'h420);
    resolve("beq_n2",  1, 0, 0, 3'b000, 32'h410,    32'h10,      32'h5,        32'h7,  1, 32'h420,    32'h410,     0, 32'h420,      1, 32'h414,      1, 32'h420);
    look("beq_wnt", 32'h410, 1'b0, 32'h414);
    resolve("bne",     1, 0, 0, 3'b001, 32'h500,    32'hFFFFFFF8, 32'h5,       32'h6,  0, 32'h0,      32'h1000,    1, 32'h4F8,      1, 32'h4F8,      0, 32'h1004);
    resolve("bge",     1, 0, 0, 3'b101, 32'h600,    32'h20,      32'h1,  32'hFFFFFFFF,  1, 32'h620,    32'h1000,    1, 32'h620,      0, 32'h620,      0, 32'h1004);
    resolve("bgeu",    1, 0, 0, 3'b111, 32'h700,    32'h20,      32'h1,  32'hFFFFFFFF,  0, 32'h0,      32'h1000,    0, 32'h720,      0, 32'h704,      0, 32'h1004);
    resolve("f3_010",  1, 0, 0, 3'b010, 32'h710,    32'h20,      32'h3,        32'h3,  0, 32'h0,      32'h1000,    0, 32'h730,      0, 32'h714,      0, 32'h1004);
    resolve("jal_wrap",0, 1, 0, 3'b000, 32'hFFFFFFFC, 32'h8,     32'h0,        32'h0,  0, 32'h0,      32'h1000,    1, 32'h4,        1, 32'h4,        0, 32'h1004);
    for (int i = 0; i < 20; i++) begin
      resolve("jal_loop", 0, 1, 0, 3'b000, 32'h800, 32'h10, 32'h0, 32'h0, 0, 32'h0,
              32'h1000, 1, 32'h810, 1, 32'h810, 0, 32'h1004);
    end
    look("jal_hit", 32'h800, 1'b1, 32'h810);

    // async reset asserted mid-cycle while a jump is being resolved
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_branch = 1'b0; ex_jump = 1'b1; ex_jalr = 1'b0;
    ex_pc = 32'h900; ex_immext = 32'h40; ex_pred_taken = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1 ex_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    exp_bc = 0; exp_mc = 0;
    look("rst_900", 32'h900, 1'b0, 32'h904);
    look("rst_800", 32'h800, 1'b0, 32'h804);
    look("rst_200", 32'h200, 1'b0, 32'h204);

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the single-cycle branch/target logic.
- Resolves all six RV32I conditional branches plus JAL/JALR.
- Adds a direct-mapped BTB with 2-bit saturating direction counters for fetch-side prediction, misprediction detection with redirect, and saturating performance counters.
- Sits between fetch (lookup port) and execute (resolve port); tables update on the clock edge after resolution.

Parameters:
- XLEN, 32, datapath/PC width.
- ENTRIES, 64, BTB/BHT entry count; power of two, ≥2.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- fetch_pc  in  XLEN  PC being fetched.
- pred_taken  out  1  fetch-side prediction: taken.
- pred_target  out  XLEN  predicted next PC; fetch_pc+4 when not taken.
- ex_valid  in  1  execute-stage instruction valid.
- ex_branch  in  1  conditional branch.
- ex_jump  in  1  JAL or JALR.
- ex_jalr  in  1  JALR (qualifies ex_jump).
- ex_funct3  in  3  branch condition code.
- ex_pc  in  XLEN  PC of the execute instruction.
- ex_immext  in  XLEN  sign-extended immediate.
- ex_rs1  in  XLEN  rs1 operand.
- ex_rs2  in  XLEN  rs2 operand.
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction.
- ex_pred_target  in  XLEN  predicted target carried down the pipe.
- take_branch  out  1  actual outcome: taken.
- pc_target  out  XLEN  computed target.
- mispredict  out  1  redirect request.
- redirect_pc  out  XLEN  correct next PC.
- branch_count  out  CNT_W  resolved branches/jumps.
- mispredict_count  out  CNT_W  mispredictions.

Behaviour:
- Index = pc[IDX_W+1:2], IDX_W = log2(ENTRIES); tag = pc[XLEN-1:IDX_W+2].
- Entry state: valid, tag, target, is_jump, ctr[1:0].
- Lookup (combinational on fetch_pc):
  - hit = valid & tag match.
  - pred_taken = hit & (is_jump | ctr[1]).
  - pred_target = pred_taken ? target : fetch_pc+4.
- Condition by funct3:
  - 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - 010 and 011 evaluate as not taken.
- take_branch = ex_valid & (ex_jump | (ex_branch & cond)).
- pc_target:
  - ex_jalr: (ex_rs1+ex_immext) with bit 0 cleared.
  - otherwise ex_pc+ex_immext.
  - All adds are modulo 2^XLEN and wrap silently.
- Resolve outputs are combinational from ex_* inputs, in the same cycle.
- mispredict = ex_valid & (take_branch != ex_pred_taken | (take_branch & pc_target != ex_pred_target)).
  - Covers a non-branch predicted taken through aliasing; redirect_pc = ex_pc+4 in that case.
- redirect_pc = take_branch ? pc_target : ex_pc+4.
- Update on rising clk, when ex_valid & (ex_branch|ex_jump):
  - Conditional branch, entry hit: ctr saturating ±1 per outcome (11 does not increment, 00 does not decrement); target rewritten when taken.
  - Conditional branch, miss and taken: allocate valid=1, tag, target, is_jump=0, ctr=10.
  - Conditional branch, miss and not taken: no allocation.
  - Jump: allocate or overwrite with is_jump=1, ctr=11, target=pc_target.
  - ex_valid & ex_pred_taken & !ex_branch & !ex_jump: invalidate the entry at index(ex_pc).
- Lookup and update hitting the same index in one cycle: lookup returns pre-update contents (read-before-write).
- branch_count increments on every valid branch/jump; mispredict_count increments on every mispredict. Both saturate at all-ones.
- Reset (async, any time, including mid-update):
  - All valid bits cleared; all ctr = 01.
  - Both counters = 0.
  - No update is committed on the reset edge.
  - Outputs then follow the combinational rules: pred_taken=0, pred_target=fetch_pc+4.
- ex_valid=0 forces take_branch=0, mispredict=0, and no table or counter update.

Decomposition:
- Shared package bp_pkg: funct3 localparams (BEQ, BNE, BLT, BGE, BLTU, BGEU), 2-bit counter encodings (SNT, WNT, WT, ST), btb_entry_t struct, and a sat_inc/sat_dec counter function.
- One natural sub-module: branch_cond (pure combinational funct3 comparator), reused by any later pipelined core.

Test Plan:
- Reset then fetch_pc=0x100 -> pred_taken=0, pred_target=0x104; both counters 0.
- BLT, rs1=0xFFFFFFFF, rs2=1, pc=0x200, imm=0x40, pred 0 -> take_branch=1, pc_target=0x240, mispredict=1, redirect_pc=0x240. Next cycle fetch 0x200 -> pred_taken=1 (ctr 10), pred_target=0x240.
- Same operands with BLTU -> not taken; with ex_pred_taken=1, ex_pred_target=0x240 -> mispredict=1, redirect_pc=0x204, ctr 10→01.
- JALR rs1=0x1003, imm=0 -> pc_target=0x1002. Entry allocated with is_jump=1; a repeat with ex_pred_target=0x1002 -> mispredict=0.
- Four taken resolutions at one PC -> ctr stays 11. Alias at the same index with a different tag -> pred_taken=0. Predicted-taken non-branch -> entry invalidated.
- CNT_W=4, 20 mispredicts -> mispredict_count holds 0xF. Assert rst mid-stream -> all entries miss, counters 0.
